// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass, per-register pending-write
// scoreboard and a sequenced bulk-clear sweep. Reads are combinational; each
// read port is its own instance so NRD scales without touching the top.

// One read port: zero-register masking, writeback bypass, busy lookup.
module regfile_scoreboard_rdport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic [AW-1:0]                 rs,
  input  logic [NREGS-1:0][XLEN-1:0]    regs,
  input  logic [NREGS-1:0]              busy,
  input  logic                          byp_en,
  input  logic [AW-1:0]                 wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  output logic [XLEN-1:0]               data,
  output logic                          busy_o
);
  logic zr, hit;

  // Register 0 reads as a hard zero; bypass only forwards real writes.
  always_comb begin
    zr     = (ZERO_REG != 0) && (rs == '0);
    hit    = byp_en && (wb_addr == rs) && !zr;
    data   = regs[rs];
    busy_o = busy[rs] & ~hit;
    if (zr) begin
      data   = '0;
      busy_o = 1'b0;
    end else if (hit) begin
      data   = wb_data;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NRD*AW-1:0]     RS,
  output logic [NRD*XLEN-1:0]   DATA,
  output logic [NRD-1:0]        BUSY,
  input  logic                  ISSUE_VALID,
  input  logic [AW-1:0]         ISSUE_RD,
  input  logic                  WB_EN,
  input  logic [AW-1:0]         WB_ADDR,
  input  logic [XLEN-1:0]       WB_DATA,
  input  logic                  CLEAR_REQ,
  output logic                  CLEAR_BUSY,
  output logic                  CLEAR_DONE
);
  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  localparam bit          ZR    = (ZERO_REG != 0);
  localparam logic [AW-1:0] FIRST = ZR ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  state_t                     state;
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [AW-1:0]              cnt;
  logic                       done_q;
  logic                       idle, wr_ok, iss_ok;

  assign idle   = (state == IDLE);
  assign wr_ok  = WB_EN && !(ZR && WB_ADDR == '0);
  assign iss_ok = ISSUE_VALID && !(ZR && ISSUE_RD == '0);

  assign CLEAR_BUSY = (state == SWEEP);
  assign CLEAR_DONE = done_q;

  // Write/issue port in IDLE, one register per cycle cleared in SWEEP.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      regs   <= '0;
      busy   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (wr_ok) begin
            regs[WB_ADDR] <= WB_DATA;
            busy[WB_ADDR] <= 1'b0;
          end
          // Issue after writeback so a same-register collision leaves busy set.
          if (iss_ok) busy[ISSUE_RD] <= 1'b1;
          if (CLEAR_REQ) begin
            state <= SWEEP;
            cnt   <= FIRST;
          end
        end
        SWEEP: begin
          regs[cnt] <= '0;
          busy[cnt] <= 1'b0;
          // Terminal index checked before increment: the counter never wraps.
          if (cnt == LAST) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      regfile_scoreboard_rdport #(
        .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)
      ) u_rd (
        .rs     (RS[k*AW +: AW]),
        .regs   (regs),
        .busy   (busy),
        .byp_en (idle && WB_EN),
        .wb_addr(WB_ADDR),
        .wb_data(WB_DATA),
        .data   (DATA[k*XLEN +: XLEN]),
        .busy_o (BUSY[k])
      );
    end
  endgenerate
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline's integer register file.
- Configurable data width, register count and read-port count.
- Adds write-to-read bypass, a per-register pending-write scoreboard (busy bits) for hazard detection in decode, and a sequenced bulk-clear engine.
- Sits between decode (read/issue) and writeback in the RV32IM pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥ 4).
- NRD, 2, number of read ports.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and issues.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- RS  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- DATA  output  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
- BUSY  output  NRD  per-port flag: the addressed register has a pending write.
- ISSUE_VALID  input  1  marks ISSUE_RD as pending-write.
- ISSUE_RD  input  AW  destination register of the issuing instruction.
- WB_EN  input  1  writeback enable.
- WB_ADDR  input  AW  writeback register.
- WB_DATA  input  XLEN  writeback data.
- CLEAR_REQ  input  1  request bulk clear of all registers.
- CLEAR_BUSY  output  1  high while a clear sweep is in progress.
- CLEAR_DONE  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- **Reset:** RESET_N low asynchronously zeroes all registers and busy bits, forces FSM to IDLE and clears the sweep counter.
  - Outputs during and after reset: DATA=0, BUSY=0, CLEAR_BUSY=0, CLEAR_DONE=0.
  - Reset asserted mid-sweep aborts the sweep with no CLEAR_DONE.
- **Reads:** combinational, zero latency; DATA[k]=regs[RS[k]].
  - Zero-register rule: ZERO_REG=1 and RS[k]==0 → DATA[k]=0 and BUSY[k]=0.
- **Bypass (IDLE only):** if WB_EN and WB_ADDR==RS[k] (and not the zero register), then DATA[k]=WB_DATA and BUSY[k]=0 in the same cycle.
- **Write:** on the rising edge in IDLE with WB_EN=1, regs[WB_ADDR]<=WB_DATA and busy[WB_ADDR]<=0.
  - Writes to register 0 are dropped when ZERO_REG=1.
  - Writeback to a non-busy register still writes the data; the busy bit stays 0.
- **Issue:** on the rising edge in IDLE with ISSUE_VALID=1, busy[ISSUE_RD]<=1.
  - Visible on BUSY from the next cycle; no same-cycle effect on BUSY.
  - Issue to register 0 is ignored when ZERO_REG=1.
- **Simultaneous issue and writeback to the same register:** data is written and busy ends at 1 (issue wins, new producer).
- **Simultaneous issue and writeback to different registers:** both take effect.
- **BUSY[k]** = busy[RS[k]] & ~(bypass hit on port k).
- **FSM states:** IDLE, SWEEP.
  - IDLE→SWEEP on CLEAR_REQ=1.
    - Counter loads first index: 1 if ZERO_REG=1, else 0.
    - Any issue/writeback in that same cycle is still applied.
  - Each SWEEP cycle: regs[cnt]<=0, busy[cnt]<=0, cnt<=cnt+1.
  - SWEEP→IDLE after clearing index NREGS-1; CLEAR_DONE=1 on the first IDLE cycle only.
  - Sweep length: NREGS-1 cycles (ZERO_REG=1) or NREGS cycles (ZERO_REG=0).
  - Counter is AW bits wide; the terminal index is compared before increment, so no wrap is ever observed.
- **During SWEEP:**
  - CLEAR_BUSY=1.
  - WB_EN, ISSUE_VALID and CLEAR_REQ are ignored (dropped, not queued).
  - Bypass is disabled.
  - Reads return current stored contents, partially cleared.
  - Caller stalls on CLEAR_BUSY.
- **CLEAR_REQ held high:** a new sweep starts in the CLEAR_DONE cycle, so back-to-back sweeps are legal.
- **Multiple read ports** may address the same register; each sees an identical result.

Test Plan:
1. Reset then write: pulse RESET_N low; WB_EN=1, WB_ADDR=5, WB_DATA=0xA5A5A5A5 for one edge; RS[0]=5 → DATA[0]=0xA5A5A5A5 next cycle; all other regs read 0.
2. Bypass: WB_EN=1, WB_ADDR=7, WB_DATA=0x12345678, RS[1]=7 in the same cycle → DATA[1]=0x12345678 before the edge; with ZERO_REG=1, WB_ADDR=0 write → RS[0]=0 reads 0 afterwards.
3. Scoreboard: ISSUE_VALID, ISSUE_RD=3 → BUSY[0]=1 (RS[0]=3) next cycle; WB to 3 with 0xDEADBEEF → BUSY[0]=0 and DATA[0]=0xDEADBEEF in the same cycle; busy bit stays clear afterwards.
4. Issue/writeback collision: reg 9 busy; ISSUE_RD=9 and WB_ADDR=9 (data 0x55) on the same edge → reg 9 = 0x55, BUSY still 1.
5. Sweep (NREGS=32, ZERO_REG=1): fill regs 1..31 and set busy on 4; pulse CLEAR_REQ → CLEAR_BUSY high for exactly 31 cycles, a WB during the sweep is dropped, CLEAR_DONE pulses once; then all regs read 0 and all BUSY=0.
6. Reset mid-sweep: assert RESET_N low at sweep cycle 10 → immediate CLEAR_BUSY=0, all DATA=0, no CLEAR_DONE pulse after release.
